// File: rtl/nco_voice_allocator.sv
// nco_voice_allocator: shares a bank of nco voices between note-on/off requests via a scan/commit FSM.
package mypackage;
  localparam int FREQUENCY_BITS = 24;
  localparam int FREQUENCY_FRACTIONAL_BITS = 8;
  typedef logic [FREQUENCY_BITS-1:0] frequency;
endpackage

module nco_voice_allocator #(
  parameter int VOICES = 4,
  parameter int AGE_BITS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic note_valid,
  output logic note_ready,
  input  logic note_on,
  input  logic [6:0] note_key,
  input  mypackage::frequency note_freq,
  output mypackage::frequency [VOICES-1:0] voice_freq,
  output logic [VOICES-1:0] voice_enable,
  output logic [VOICES-1:0] voice_restart,
  output logic stolen,
  output logic [$clog2(VOICES+1)-1:0] active_count
);
  localparam int IW = $clog2(VOICES);
  localparam int CW = $clog2(VOICES+1);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state;
  logic [6:0] key [VOICES];
  logic [AGE_BITS-1:0] age [VOICES];
  logic req_on;
  logic [6:0] req_key;
  mypackage::frequency req_freq;
  logic [IW-1:0] idx, hit_idx, free_idx, old_idx, tgt;
  logic hit, free_ok, old_ok;
  logic [AGE_BITS-1:0] old_age;
  assign note_ready = (state == IDLE) && !reset;
  // retrigger beats free slot beats stealing the oldest
  assign tgt = hit ? hit_idx : free_ok ? free_idx : old_idx;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      hit <= 1'b0;
      free_ok <= 1'b0;
      old_ok <= 1'b0;
      hit_idx <= '0;
      free_idx <= '0;
      old_idx <= '0;
      old_age <= '0;
      req_on <= 1'b0;
      req_key <= '0;
      req_freq <= '0;
      voice_freq <= '0;
      voice_enable <= '0;
      voice_restart <= '0;
      stolen <= 1'b0;
      active_count <= '0;
      for (int i = 0; i < VOICES; i++) begin
        key[i] <= '0;
        age[i] <= '0;
      end
    end else begin
      voice_restart <= '0;
      stolen <= 1'b0;
      case (state)
        IDLE: if (note_valid) begin
          req_on <= note_on;
          req_key <= note_key;
          req_freq <= note_freq;
          hit <= 1'b0;
          free_ok <= 1'b0;
          old_ok <= 1'b0;
          idx <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (voice_enable[idx] && key[idx] == req_key && !hit) begin
            hit <= 1'b1;
            hit_idx <= idx;
          end
          if (!voice_enable[idx] && !free_ok) begin
            free_ok <= 1'b1;
            free_idx <= idx;
          end
          // strict compare keeps the lowest index on equal ages
          if (voice_enable[idx] && (!old_ok || age[idx] > old_age)) begin
            old_ok <= 1'b1;
            old_idx <= idx;
            old_age <= age[idx];
          end
          idx <= idx + IW'(1);
          if (idx == IW'(VOICES-1)) state <= COMMIT;
        end
        COMMIT: begin
          state <= IDLE;
          if (req_on) begin
            for (int i = 0; i < VOICES; i++)
              if (IW'(i) != tgt && voice_enable[i])
                age[i] <= age[i] + AGE_BITS'(age[i] != '1);
            voice_enable[tgt] <= 1'b1;
            voice_freq[tgt] <= req_freq;
            key[tgt] <= req_key;
            age[tgt] <= '0;
            voice_restart[tgt] <= !hit;
            stolen <= !hit && !free_ok;
            if (!hit && free_ok) active_count <= active_count + CW'(1);
          end else if (hit) begin
            voice_enable[hit_idx] <= 1'b0;
            age[hit_idx] <= '0;
            active_count <= active_count - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
